// File: rtl/fifo_tx_scheduler.sv
// fifo_tx_scheduler: pops 32-bit debug words from a FIFO and hands them LSB byte first to a UART TX.
// Optional feature macro TX_CHECKSUM_EN appends a running XOR checksum byte after every END_WORD frame.
module fifo_tx_scheduler #(
  parameter logic [31:0] END_WORD = 32'h656E6464
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_data,
  output logic        o_fifo_rd_en,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [15:0] o_words_sent
);

`ifdef TX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RD, LATCH, SEND, WAIT, CHK_SEND, CHK_WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD, LATCH, SEND, WAIT} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        rd_en_q, rd_en_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] words_sent_q, words_sent_d;
  logic [7:0]  cur_byte;
`ifdef TX_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  assign cur_byte = word_q[{byte_idx_q, 3'b000} +: 8];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    rd_en_d      = 1'b0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    words_sent_d = words_sent_q;
`ifdef TX_CHECKSUM_EN
    chk_d        = chk_q;
`endif

    case (state_q)
      IDLE: begin
        if (!i_fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = RD;
        end
      end
      RD: state_d = LATCH;
      LATCH: begin
        word_d     = i_fifo_data;
        byte_idx_d = 2'd0;
        state_d    = SEND;
      end
      SEND: begin
        tx_data_d  = cur_byte;
        tx_start_d = 1'b1;
`ifdef TX_CHECKSUM_EN
        chk_d      = chk_q ^ cur_byte;
`endif
        state_d    = WAIT;
      end
      WAIT: begin
        if (i_tx_done) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = SEND;
          end else if (word_q == END_WORD) begin
`ifdef TX_CHECKSUM_EN
            // The word is only counted once its trailing checksum byte has gone out.
            state_d      = CHK_SEND;
`else
            words_sent_d = words_sent_q + 16'd1;
            frame_done_d = 1'b1;
            state_d      = IDLE;
`endif
          end else begin
            words_sent_d = words_sent_q + 16'd1;
            state_d      = IDLE;
          end
        end
      end
`ifdef TX_CHECKSUM_EN
      CHK_SEND: begin
        tx_data_d  = chk_q;
        tx_start_d = 1'b1;
        state_d    = CHK_WAIT;
      end
      CHK_WAIT: begin
        if (i_tx_done) begin
          words_sent_d = words_sent_q + 16'd1;
          frame_done_d = 1'b1;
          chk_d        = 8'h00;
          state_d      = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      // NOTE: the word register is reset too, so a discarded word can never leak into a later byte.
      word_q       <= '0;
      byte_idx_q   <= '0;
      rd_en_q      <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      words_sent_q <= '0;
`ifdef TX_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      byte_idx_q   <= byte_idx_d;
      rd_en_q      <= rd_en_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      words_sent_q <= words_sent_d;
`ifdef TX_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign o_fifo_rd_en = rd_en_q;
  assign o_tx_start   = tx_start_q;
  assign o_tx_data    = tx_data_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_words_sent = words_sent_q;

endmodule
